// File: rtl/comm_pkg.sv
// Shared definitions for the quadcopter command master.
// Contents:
//   - opcode constants sent as the first byte of a command frame
//   - positive-acknowledge response byte
//   - frame FSM and receiver FSM state types
package comm_pkg;

  localparam logic [7:0] REQ_BATT  = 8'h01;
  localparam logic [7:0] SET_PTCH  = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] CALIBRATE = 8'h06;
  localparam logic [7:0] EMER_LAND = 8'h07;
  localparam logic [7:0] MTRS_OFF  = 8'h08;

  localparam logic [7:0] POS_ACK   = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    SEND_HI,
    SEND_MID,
    SEND_LO,
    DONE
  } frm_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/comm_uart.sv
// Byte-level UART transmitter and receiver (8N1, LSB first).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   trmt          : load tx_data and start a byte (see handshake below)
//   tx_data       : byte to transmit
//   tx_done       : high during the last clock of the stop bit
//   tx            : serial out, idle high
//   rx            : serial in, asynchronous, idle high
//   rx_rdy        : one-cycle strobe, byte with valid stop bit in rx_data
//   rx_data       : received byte (valid while rx_rdy is high)
//
// Handshake: trmt is accepted whenever the transmitter is idle or tx_done is
// high in the same cycle; a trmt during tx_done chains the next byte with no
// idle gap between the stop bit and the following start bit. trmt at any
// other time is ignored. rx_rdy is a single-cycle strobe with no backpressure.
module comm_uart
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       tx,
  input  logic       rx,
  output logic       rx_rdy,
  output logic [7:0] rx_data
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  // ---------------- transmitter ----------------
  // tx is the LSB of a shift register that fills with ones, so the line
  // returns to idle-high on its own after the stop bit.
  logic [9:0]    tx_shift;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic          tx_busy;

  assign tx      = tx_shift[0];
  assign tx_done = tx_busy && (tx_cnt == BIT_LAST) && (tx_bit == 4'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift <= '1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_busy  <= 1'b0;
    end else if (trmt && (!tx_busy || tx_done)) begin
      tx_shift <= {1'b1, tx_data, 1'b0};
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_busy  <= 1'b1;
    end else if (tx_busy) begin
      if (tx_cnt == BIT_LAST) begin
        tx_cnt   <= '0;
        tx_shift <= {1'b1, tx_shift[9:1]};
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
        end else begin
          tx_bit <= tx_bit + 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  // ---------------- receiver ----------------
  logic          rx_s1, rx_s2, rx_prev;
  logic          rx_fall;
  rx_state_t     rx_state, rx_nxt;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;

  assign rx_fall = rx_prev && !rx_s2;
  assign rx_data = rx_shift;
  assign rx_rdy  = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST) && rx_s2;

  always_comb begin
    rx_nxt = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_nxt = RX_START;
      // A start bit that reads high at its centre was a glitch.
      RX_START: if (rx_cnt == HALF_LAST) rx_nxt = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if ((rx_cnt == BIT_LAST) && (rx_bit == 3'd7)) rx_nxt = RX_STOP;
      RX_STOP:  if (rx_cnt == BIT_LAST) rx_nxt = RX_IDLE;
      default:  rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_nxt;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
        end
        RX_START: rx_cnt <= (rx_cnt == HALF_LAST) ? '0 : rx_cnt + 1'b1;
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: rx_cnt <= (rx_cnt == BIT_LAST) ? '0 : rx_cnt + 1'b1;
        default: rx_cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/comm_master.sv
// UART command master: sends {cmd, data[15:8], data[7:0]} as one 3-byte
// frame and collects single-byte responses from the copter.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   cmd, data     : opcode and payload, latched when snd_cmd is accepted
//   snd_cmd       : one-cycle send request, accepted only in IDLE
//   clr_resp_rdy  : host acknowledge of resp
//   RX, TX        : serial lines, idle high
//   frm_snt       : set when the frame's last stop bit ends, cleared on the
//                   next accepted snd_cmd
//   resp, resp_rdy: last valid response byte and its pending flag
module comm_master
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  input  logic        snd_cmd,
  input  logic        clr_resp_rdy,
  input  logic        RX,
  output logic        TX,
  output logic        frm_snt,
  output logic [7:0]  resp,
  output logic        resp_rdy
);

  frm_state_t  state, nxt;
  logic [15:0] data_buf;
  logic        accept;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        rx_rdy;
  logic [7:0]  rx_data;

  assign accept = (state == IDLE) && snd_cmd;

  // The opcode goes straight from cmd into the UART on the accept cycle, so
  // only the payload needs buffering.
  always_comb begin
    nxt     = state;
    trmt    = 1'b0;
    tx_data = cmd;
    case (state)
      IDLE: begin
        if (snd_cmd) begin
          trmt = 1'b1;
          nxt  = SEND_HI;
        end
      end
      SEND_HI: begin
        if (tx_done) begin
          trmt    = 1'b1;
          tx_data = data_buf[15:8];
          nxt     = SEND_MID;
        end
      end
      SEND_MID: begin
        if (tx_done) begin
          trmt    = 1'b1;
          tx_data = data_buf[7:0];
          nxt     = SEND_LO;
        end
      end
      SEND_LO: if (tx_done) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      data_buf <= '0;
      frm_snt  <= 1'b0;
      resp     <= '0;
      resp_rdy <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        data_buf <= data;
        frm_snt  <= 1'b0;
      end else if ((state == SEND_LO) && tx_done) begin
        frm_snt <= 1'b1;
      end
      // A new byte wins over a same-cycle clear.
      if (rx_rdy) begin
        resp     <= rx_data;
        resp_rdy <= 1'b1;
      end else if (clr_resp_rdy || accept) begin
        resp_rdy <= 1'b0;
      end
    end
  end

  comm_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk    (clk),
    .rst    (rst),
    .trmt   (trmt),
    .tx_data(tx_data),
    .tx_done(tx_done),
    .tx     (TX),
    .rx     (RX),
    .rx_rdy (rx_rdy),
    .rx_data(rx_data)
  );

endmodule

// File: tb/tb_comm_master.sv
// Bench for comm_master with BAUD_DIV=16: a TX line decoder and a response
// watcher pop expected bytes from queues filled by the stimulus tasks.
module tb_comm_master;
  import comm_pkg::*;

  localparam int B = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        snd_cmd;
  logic        clr_resp_rdy;
  logic        rx;
  logic        tx;
  logic        frm_snt;
  logic [7:0]  resp;
  logic        resp_rdy;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] resp_q[$];
  bit mon_off  = 1'b0;
  bit rdy_seen = 1'b0;

  comm_master #(.BAUD_DIV(B)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmd),
    .data        (data),
    .snd_cmd     (snd_cmd),
    .clr_resp_rdy(clr_resp_rdy),
    .RX          (rx),
    .TX          (tx),
    .frm_snt     (frm_snt),
    .resp        (resp),
    .resp_rdy    (resp_rdy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // ---------------- TX monitor: decode bytes off the wire ----------------
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst && !mon_off && tx === 1'b0) begin
        repeat (B / 2) @(negedge clk);
        check("tx_start_bit", {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          b[i] = tx;
        end
        repeat (B) @(negedge clk);
        check("tx_stop_bit", {31'd0, tx}, 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_extra_byte: got %0h expected none", b);
        end else begin
          check("tx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    logic       pr;
    logic [7:0] presp;
    pr = 1'b0;
    presp = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && ((resp_rdy && !pr) || resp !== presp)) begin
        if (resp_rdy && !pr) rdy_seen = 1'b1;
        if (resp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected: got %0h expected none", resp);
        end else begin
          check("resp_byte", {24'd0, resp}, {24'd0, resp_q.pop_front()});
        end
      end
      pr = resp_rdy;
      presp = resp;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_rx(input logic [7:0] b, input logic stop);
    if (stop) resp_q.push_back(b);
    @(negedge clk);
    rx = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (B) @(negedge clk);
    end
    rx = stop;
    repeat (B) @(negedge clk);
    rx = 1'b1;
  endtask

  // busy_at >= 0 issues a second request that many clocks into the frame.
  task automatic send_frame(input logic [7:0] c, input logic [15:0] d, input int busy_at);
    int n;
    @(negedge clk);
    cmd = c;
    data = d;
    snd_cmd = 1'b1;
    exp_q.push_back(c);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
    @(negedge clk);
    snd_cmd = 1'b0;
    check("frm_snt_cleared", {31'd0, frm_snt}, 32'd0);
    n = 0;
    while (frm_snt !== 1'b1 && n < 1000) begin
      if (n == busy_at) begin
        cmd = CALIBRATE;
        data = 16'hFFFF;
        snd_cmd = 1'b1;
      end else begin
        snd_cmd = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    snd_cmd = 1'b0;
    check("frame_length", n, 30 * B);
    repeat (3) @(negedge clk);
    check("frm_snt_held", {31'd0, frm_snt}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] v;
    rst = 1'b1;
    cmd = 8'h00;
    data = 16'h0000;
    snd_cmd = 1'b0;
    clr_resp_rdy = 1'b0;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_frm_snt", {31'd0, frm_snt}, 32'd0);
    check("reset_resp_rdy", {31'd0, resp_rdy}, 32'd0);
    check("reset_resp", {24'd0, resp}, 32'd0);
    rst = 1'b0;

    send_frame(SET_PTCH, 16'h002A, -1);
    repeat (5) @(negedge clk);
    send_frame(SET_ROLL, 16'h5A3C, 100);
    repeat (40 * B) @(negedge clk);
    check("tx_queue_drained", exp_q.size(), 0);

    send_rx(POS_ACK, 1'b1);
    check("ack_resp", {24'd0, resp}, {24'd0, POS_ACK});
    check("ack_resp_rdy", {31'd0, resp_rdy}, 32'd1);
    clr_resp_rdy = 1'b1;
    @(negedge clk);
    clr_resp_rdy = 1'b0;
    check("clr_resp_rdy", {31'd0, resp_rdy}, 32'd0);
    check("clr_keeps_resp", {24'd0, resp}, {24'd0, POS_ACK});

    send_rx(8'h3C, 1'b0);
    repeat (2 * B) @(negedge clk);
    check("bad_stop_resp", {24'd0, resp}, {24'd0, POS_ACK});
    check("bad_stop_rdy", {31'd0, resp_rdy}, 32'd0);

    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (12 * B) @(negedge clk);
    check("glitch_resp", {24'd0, resp}, {24'd0, POS_ACK});
    check("glitch_rdy", {31'd0, resp_rdy}, 32'd0);

    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    check("overwrite_resp", {24'd0, resp}, 32'h22);
    check("overwrite_rdy", {31'd0, resp_rdy}, 32'd1);

    send_frame(REQ_BATT, 16'h0000, -1);
    check("accept_clears_rdy", {31'd0, resp_rdy}, 32'd0);
    check("accept_keeps_resp", {24'd0, resp}, 32'h22);

    // Clear held across the whole reception: resp_rdy can only be seen high
    // if the set beats the clear on the set cycle.
    rdy_seen = 1'b0;
    @(negedge clk);
    clr_resp_rdy = 1'b1;
    send_rx(8'h5C, 1'b1);
    clr_resp_rdy = 1'b0;
    check("set_wins_over_clr", {31'd0, rdy_seen}, 32'd1);
    check("collision_resp", {24'd0, resp}, 32'h5C);

    // Full duplex: random frames with random responses arriving meanwhile.
    for (int k = 0; k < 4; k++) begin
      fork
        send_frame(8'($urandom_range(1, 8)), 16'($urandom), -1);
        begin
          repeat ($urandom_range(0, 50)) @(negedge clk);
          v = 8'($urandom_range(0, 255));
          send_rx(v, 1'b1);
          check("duplex_resp", {24'd0, resp}, {24'd0, v});
          check("duplex_rdy", {31'd0, resp_rdy}, 32'd1);
          clr_resp_rdy = 1'b1;
          @(negedge clk);
          clr_resp_rdy = 1'b0;
        end
      join
    end
    repeat (4) @(negedge clk);

    // Reset mid-frame; opcode 00 keeps TX low through the first byte.
    mon_off = 1'b1;
    cmd = 8'h00;
    data = 16'hFFFF;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    repeat (50) @(negedge clk);
    check("midframe_tx_low", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_tx", {31'd0, tx}, 32'd1);
    check("rst_mid_frm_snt", {31'd0, frm_snt}, 32'd0);
    check("rst_mid_resp", {24'd0, resp}, 32'd0);
    check("rst_mid_resp_rdy", {31'd0, resp_rdy}, 32'd0);
    rst = 1'b0;
    repeat (4 * B) @(negedge clk);
    check("post_rst_tx_idle", {31'd0, tx}, 32'd1);
    check("post_rst_frm_snt", {31'd0, frm_snt}, 32'd0);

    check("final_tx_queue", exp_q.size(), 0);
    check("final_resp_queue", resp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so a stuck run still reports.
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: got no end expected end before limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
